hacd_reg2axil_master: RTL and testbench
=======================================

HACD_REG2AXIL_MASTER -- requirements
Module: hacd_reg2axil_master

Interface
REQ-001: Parameter HacdBase, 64'h000000fff5100000, 64-bit base added to every register word address.
REQ-002: clk_i  input  1  single clock; all logic on rising edge.
REQ-003: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004: req_valid_i  input  1  register request present; held by requester until resp_ready_o.
REQ-005: req_write_i  input  1  1 = write, 0 = read; stable while req_valid_i.
REQ-006: req_addr_i  input  32  byte offset from HacdBase; bits [1:0] ignored.
REQ-007: req_wdata_i  input  32  write word.
REQ-008: req_wstrb_i  input  4  write byte enables.
REQ-009: resp_ready_o  output  1  one-cycle completion pulse.
REQ-010: resp_rdata_o  output  32  read word, valid with resp_ready_o, held until next read completes.
REQ-011: resp_error_o  output  1  1 = AXI response not OKAY, valid with resp_ready_o.
REQ-012: m_axi_awaddr  output  64  AXI-lite write address.
REQ-013: m_axi_awvalid  output  1  write address valid.
REQ-014: m_axi_awready  input  1  write address ready.
REQ-015: m_axi_wdata  output  64  write data.
REQ-016: m_axi_wstrb  output  8  write strobes.
REQ-017: m_axi_wvalid  output  1  write data valid.
REQ-018: m_axi_wready  input  1  write data ready.
REQ-019: m_axi_bresp  input  2  write response.
REQ-020: m_axi_bvalid  input  1  write response valid.
REQ-021: m_axi_bready  output  1  write response ready.
REQ-022: m_axi_araddr  output  64  AXI-lite read address.
REQ-023: m_axi_arvalid  output  1  read address valid.
REQ-024: m_axi_arready  input  1  read address ready.
REQ-025: m_axi_rdata  input  64  read data.
REQ-026: m_axi_rresp  input  2  read response.
REQ-027: m_axi_rvalid  input  1  read data valid.
REQ-028: m_axi_rready  output  1  read data ready.

Function
REQ-029: States Idle, WrReq, WrResp, RdReq, RdData, Resp; requests accepted only in Idle; one outstanding transaction.
REQ-030: Idle with req_valid_i: latch request; write -> WrReq, read -> RdReq; awvalid/wvalid or arvalid registered, asserted the following cycle.
REQ-031: Address = HacdBase + {32'b0, req_addr_i[31:2], 2'b00}, 64-bit modulo-2^64 add; same value drives awaddr or araddr.
REQ-032: wdata = {req_wdata_i, req_wdata_i}; wstrb = {4'b0, req_wstrb_i} if addr[2]=0, else {req_wstrb_i, 4'b0}; wstrb 0 still issues the AXI write.
REQ-033: WrReq: awvalid and wvalid drop independently on own handshake; awaddr/wdata/wstrb stable while valid; both done (incl. same cycle) -> WrResp.
REQ-034: WrResp: bready=1; on bvalid -> Resp, resp_error_o = (bresp != 2'b00).
REQ-035: RdReq: arvalid held until arready -> RdData; RdData: rready=1; on rvalid -> Resp, resp_rdata_o = addr[2] ? rdata[63:32] : rdata[31:0], resp_error_o = (rresp != 2'b00).
REQ-036: Resp: resp_ready_o=1 exactly one cycle, then Idle; req_valid_i ignored in Resp.
REQ-037: Minimum latency, zero-wait slave: request sampled cycle 0, AXI handshake cycle 1, B/R handshake cycle 2, resp_ready_o cycle 3.
REQ-038: bvalid/rvalid outside WrResp/RdData ignored; no ready asserted then.

Reset
REQ-039: rst_ni low: state Idle; awvalid, wvalid, arvalid, bready, rready, resp_ready_o, resp_error_o = 0; addresses, data, strobes, resp_rdata_o = 0; immediate, asynchronous.
REQ-040: Reset mid-transaction abandons it silently; no resp_ready_o issued for it.

Verification
REQ-041: Write addr 32'h10, wdata 32'hA5A5_0001, wstrb 4'hF, zero-wait slave -> awaddr 64'h000000fff5100010, wstrb 8'h0F, resp_ready_o at cycle 3, error 0.
REQ-042: Read addr 32'h4, rdata 64'hDEAD_BEEF_0000_1111, rresp 0 -> araddr 64'h000000fff5100004, resp_rdata_o 32'hDEADBEEF.
REQ-043: Write, awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held, single B handshake, one resp_ready_o.
REQ-044: Read with rresp 2'b10 -> resp_error_o 1, resp_rdata_o updated; write with bresp 2'b11 -> resp_error_o 1.
REQ-045: rst_ni low while arvalid pending, then release -> all outputs 0, Idle, no resp_ready_o; next request completes normally.

Source files
------------

// File: rtl/hacd_reg2axil_master.sv
// Bridges a simple single-word register request port onto a 64-bit AXI-lite master.
// One transaction in flight; 32-bit words are steered onto the 64-bit bus by address bit 2.
module hacd_reg2axil_master #(
    parameter logic [63:0] HacdBase = 64'h000000fff5100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        resp_ready_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [63:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [63:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        sel_hi_q;
    logic        awvalid_q, wvalid_q, arvalid_q;
    logic [31:0] rdata_q;
    logic        error_q;

    logic        accept;
    logic        aw_done, w_done;
    logic [63:0] req_axi_addr;
    logic        unused_addr_bits;

    assign accept           = (state_q == IDLE) && req_valid_i;
    assign req_axi_addr     = HacdBase + {32'b0, req_addr_i[31:2], 2'b00};
    assign unused_addr_bits = ^req_addr_i[1:0];

    // A channel counts as done once its valid has already dropped or is handshaking now.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = req_write_i ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_d = RESP;
            RD_REQ:  if (m_axi_arready) state_d = RD_DATA;
            RD_DATA: if (m_axi_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            sel_hi_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= req_axi_addr;
                wdata_q   <= req_wdata_i;
                wstrb_q   <= req_addr_i[2] ? {req_wstrb_i, 4'b0} : {4'b0, req_wstrb_i};
                sel_hi_q  <= req_addr_i[2];
                awvalid_q <= req_write_i;
                wvalid_q  <= req_write_i;
                arvalid_q <= !req_write_i;
            end
            if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
            if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
            if (arvalid_q && m_axi_arready) arvalid_q <= 1'b0;
            if (state_q == WR_RESP && m_axi_bvalid) begin
                error_q <= (m_axi_bresp != 2'b00);
            end
            if (state_q == RD_DATA && m_axi_rvalid) begin
                error_q <= (m_axi_rresp != 2'b00);
                rdata_q <= sel_hi_q ? m_axi_rdata[63:32] : m_axi_rdata[31:0];
            end
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_wdata   = {wdata_q, wdata_q};
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign resp_ready_o  = (state_q == RESP);
    assign resp_rdata_o  = rdata_q;
    assign resp_error_o  = error_q;

endmodule

// File: tb/tb_hacd_reg2axil_master.sv
// Directed bench for hacd_reg2axil_master: a programmable-delay AXI-lite slave,
// a transaction-level expectation model and a per-cycle output monitor.
module tb_hacd_reg2axil_master;

    localparam logic [63:0] HACD_BASE = 64'h000000fff5100000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready, resp_error;
    logic [31:0] resp_rdata;
    logic [63:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    hacd_reg2axil_master #(.HacdBase(HACD_BASE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .resp_ready_o (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_error_o (resp_error),
        .m_axi_awaddr (awaddr),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: what the bus and response must carry for one request.
    bit          txn_active = 1'b0;
    bit          exp_is_read;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] last_rd = '0;

    function automatic logic [63:0] model_addr(input logic [31:0] a);
        return HACD_BASE + 64'(a & 32'hFFFF_FFFC);
    endfunction

    function automatic logic [7:0] model_wstrb(input logic [31:0] a, input logic [3:0] s);
        logic [7:0] wide;
        wide = 8'(s);
        return a[2] ? (wide << 4) : wide;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic [63:0] d);
        return a[2] ? 32'(d >> 32) : 32'(d);
    endfunction

    // Per-cycle monitor, sampled mid low phase.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            check("reset_ctrl", {awvalid, wvalid, arvalid, bready, rready, resp_ready, resp_error}, '0);
            check("reset_addr", awaddr | araddr, '0);
            check("reset_wdata", wdata, '0);
            check("reset_wstrb_rdata", {wstrb, resp_rdata}, '0);
            last_rd = '0;
        end else if (!txn_active) begin
            check("idle_quiet", {awvalid, wvalid, arvalid, bready, rready, resp_ready}, '0);
            check("rdata_hold_idle", resp_rdata, last_rd);
        end else begin
            if (exp_is_read) begin
                check("read_no_wr_chan", {awvalid, wvalid, bready}, '0);
                if (arvalid) check("araddr", araddr, exp_addr);
            end else begin
                check("write_no_rd_chan", {arvalid, rready}, '0);
                if (awvalid) check("awaddr", awaddr, exp_addr);
                if (wvalid) begin
                    check("wdata", wdata, exp_wdata);
                    check("wstrb", wstrb, exp_wstrb);
                end
            end
            if (resp_ready) begin
                check("resp_error", resp_error, exp_err);
                if (exp_is_read) begin
                    check("resp_rdata", resp_rdata, exp_rdata);
                    last_rd = exp_rdata;
                end else begin
                    check("rdata_hold_write", resp_rdata, last_rd);
                end
            end else begin
                check("rdata_hold_busy", resp_rdata, last_rd);
            end
        end
    end

    // One request end to end. aw_d/w_d: cycles valid waits before ready (aw_d is AR for reads);
    // rsp_d: cycles after the request phase before B/R valid. stray drives bvalid during a read.
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int aw_d, input int w_d, input int rsp_d,
                           input logic [1:0] code, input logic [63:0] rd, input bit stray,
                           output logic [63:0] cap_addr, output logic [7:0] cap_wstrb,
                           output logic [31:0] cap_rdata, output logic cap_err, output int lat);
        int aw_cnt = 0, w_cnt = 0, rsp_cnt = 0;
        int aw_hs = 0, w_hs = 0, rsp_hs = 0, nresp = 0;
        bit done = 1'b0;
        bit ph;
        cap_addr = '0; cap_wstrb = '0; cap_rdata = '0; cap_err = 1'b0; lat = -1;
        @(negedge clk);
        exp_is_read = !wr;
        exp_addr    = model_addr(a);
        exp_wdata   = {wd, wd};
        exp_wstrb   = model_wstrb(a, ws);
        exp_rdata   = model_rdata(a, rd);
        exp_err     = (code != 2'b00);
        txn_active  = 1'b1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws;
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_ready) begin
                nresp++; lat = c; cap_rdata = resp_rdata; cap_err = resp_error; done = 1'b1;
            end
            if (wr) begin
                ph = (aw_hs > 0) && (w_hs > 0);
                if (aw_hs > 0) check("awvalid_dropped", awvalid, 0);
                if (w_hs > 0)  check("wvalid_dropped", wvalid, 0);
                awready = awvalid && (aw_cnt >= aw_d);
                wready  = wvalid && (w_cnt >= w_d);
                if (awvalid) aw_cnt++;
                if (wvalid)  w_cnt++;
                if (awready) begin aw_hs++; cap_addr = awaddr; end
                if (wready)  begin w_hs++; cap_wstrb = wstrb; end
                bvalid = ph && (rsp_hs == 0) && (rsp_cnt >= rsp_d);
                bresp  = code;
                if (ph) rsp_cnt++;
                if (bvalid && bready) rsp_hs++;
            end else begin
                ph = (aw_hs > 0);
                if (aw_hs > 0) check("arvalid_dropped", arvalid, 0);
                arready = arvalid && (aw_cnt >= aw_d);
                if (arvalid) aw_cnt++;
                if (arready) begin aw_hs++; cap_addr = araddr; end
                rvalid = ph && (rsp_hs == 0) && (rsp_cnt >= rsp_d);
                rdata  = rd;
                rresp  = code;
                bvalid = stray;
                bresp  = 2'b11;
                if (ph) rsp_cnt++;
                if (rvalid && rready) rsp_hs++;
            end
            if (done) begin
                req_valid = 1'b0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                arready = 1'b0; rvalid = 1'b0;
            end
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) txn_active = 1'b0;
            if (resp_ready) nresp++;
        end
        check("resp_seen", done, 1);
        check("resp_pulses", nresp, 1);
        check("addr_handshakes", aw_hs, 1);
        if (wr) check("w_handshakes", w_hs, 1);
        check("resp_handshakes", rsp_hs, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ca;
        logic [7:0]  cw;
        logic [31:0] cr;
        logic        ce;
        int          lat;

        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_rdata_after_release", resp_rdata, 0);
        check("reset_resp_ready", resp_ready, 0);

        // Zero-wait write, low word.
        run_txn(1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'b00, '0, 0, ca, cw, cr, ce, lat);
        check("w1_awaddr", ca, 64'h0000_00ff_f510_0010);
        check("w1_wstrb", cw, 8'h0F);
        check("w1_latency", lat, 3);
        check("w1_error", ce, 0);

        // Zero-wait read, high word.
        run_txn(0, 32'h4, '0, '0, 0, 0, 0, 2'b00, 64'hDEAD_BEEF_0000_1111, 0, ca, cw, cr, ce, lat);
        check("r1_araddr", ca, 64'h0000_00ff_f510_0004);
        check("r1_rdata", cr, 32'hDEAD_BEEF);
        check("r1_latency", lat, 3);
        check("r1_error", ce, 0);

        // Write with AW accepted three cycles ahead of W, high word lanes.
        run_txn(1, 32'h14, 32'h0BAD_F00D, 4'h3, 0, 3, 0, 2'b00, '0, 0, ca, cw, cr, ce, lat);
        check("w2_awaddr", ca, 64'h0000_00ff_f510_0014);
        check("w2_wstrb", cw, 8'h30);
        check("w2_latency", lat, 6);

        // Read with SLVERR, a stray bvalid present throughout.
        run_txn(0, 32'h8, '0, '0, 0, 0, 0, 2'b10, 64'h1234_5678_9ABC_DEF0, 1, ca, cw, cr, ce, lat);
        check("r2_rdata", cr, 32'h9ABC_DEF0);
        check("r2_error", ce, 1);

        // Write with empty strobe and DECERR.
        run_txn(1, 32'h20, 32'h0000_0000, 4'h0, 0, 0, 0, 2'b11, '0, 0, ca, cw, cr, ce, lat);
        check("w3_wstrb", cw, 8'h00);
        check("w3_error", ce, 1);
        check("w3_latency", lat, 3);
        check("w3_rdata_held", cr, 32'h9ABC_DEF0);

        // W ahead of AW, delayed B.
        run_txn(1, 32'h1C, 32'h1357_9BDF, 4'hC, 2, 0, 2, 2'b00, '0, 0, ca, cw, cr, ce, lat);
        check("w4_wstrb", cw, 8'hC0);
        check("w4_latency", lat, 7);
        check("w4_error", ce, 0);

        // Top offset: low bits ignored, base addition carries past bit 31.
        run_txn(0, 32'hFFFF_FFFF, '0, '0, 2, 0, 3, 2'b00, 64'hCAFE_0000_0000_BABE, 0, ca, cw, cr, ce, lat);
        check("r3_araddr", ca, 64'h0000_0100_f50f_fffc);
        check("r3_rdata", cr, 32'hCAFE_0000);
        check("r3_latency", lat, 8);

        // Reset while a read address is waiting for arready.
        @(negedge clk);
        exp_is_read = 1'b1;
        exp_addr    = model_addr(32'h8);
        exp_err     = 1'b0;
        txn_active  = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8;
        repeat (2) @(negedge clk);
        check("rst_arvalid_pending", arvalid, 1);
        #1;
        rst_n = 1'b0; req_valid = 1'b0; txn_active = 1'b0;
        #1;
        check("rst_async_clear", {arvalid, araddr, resp_ready}, '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_resp", resp_ready, 0);
        end
        run_txn(0, 32'h8, '0, '0, 0, 0, 0, 2'b00, 64'h0000_0000_5555_AAAA, 0, ca, cw, cr, ce, lat);
        check("r4_rdata", cr, 32'h5555_AAAA);
        check("r4_latency", lat, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
